// File: rtl/ppi_pkg.sv
// Shared types and constants for the PPI bus-cycle sequencer.
// nxt_phase gives the phase that follows st, skipping zero-length phases.
package ppi_pkg;

    localparam int CNT_W = 4;

    localparam logic [1:0] PORT_A = 2'd0;
    localparam logic [1:0] PORT_B = 2'd1;
    localparam logic [1:0] PORT_C = 2'd2;
    localparam logic [1:0] CTRL   = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        RECOVER
    } ppi_state_e;

    function automatic ppi_state_e nxt_phase(
        input ppi_state_e st,
        input logic       s0,
        input logic       h0,
        input logic       r0
    );
        ppi_state_e n;
        n = IDLE;
        case (st)
            IDLE:    n = s0 ? STROBE : SETUP;
            SETUP:   n = STROBE;
            STROBE:  n = !h0 ? HOLD : (!r0 ? RECOVER : IDLE);
            HOLD:    n = r0 ? IDLE : RECOVER;
            default: n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/ppi_phase_timer.sv
// Phase length counter: loaded with (length-1) of the phase being
// entered, done while the current phase is in its last cycle.
module ppi_phase_timer
    import ppi_pkg::*;
#(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 3,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  ppi_state_e tgt,
    output logic       done
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] ld_val;

    always_comb begin
        ld_val = '0;
        case (tgt)
            SETUP:   ld_val = CNT_W'(SETUP_CYC - 1);
            STROBE:  ld_val = CNT_W'(STROBE_CYC - 1);
            HOLD:    ld_val = CNT_W'(HOLD_CYC - 1);
            RECOVER: ld_val = CNT_W'(RECOVERY_CYC - 1);
            default: ld_val = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= ld_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ppi_bus_master.sv
// Sequences single register requests into registered 8255A bus cycles
// with programmable setup/strobe/hold/recovery and a read response pulse.
module ppi_bus_master
    import ppi_pkg::*;
#(
    parameter int SETUP_CYC    = 1,
    parameter int STROBE_CYC   = 3,
    parameter int HOLD_CYC     = 1,
    parameter int RECOVERY_CYC = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       nCS,
    output logic       nRD,
    output logic       nWR,
    output logic [1:0] A,
    output logic [7:0] Dout,
    output logic       Doe,
    input  logic [7:0] Din
);

    localparam bit CFG_OK =
        SETUP_CYC >= 0 && SETUP_CYC <= 15 &&
        STROBE_CYC >= 1 && STROBE_CYC <= 15 &&
        HOLD_CYC >= 0 && HOLD_CYC <= 15 &&
        RECOVERY_CYC >= 0 && RECOVERY_CYC <= 15;

    ppi_state_e state;
    ppi_state_e tgt;

    logic       wr_q;
    logic [1:0] addr_q;
    logic [7:0] wd_q;

    logic       accept;
    logic       adv;
    logic       done;
    logic       wr_n;
    logic [1:0] addr_n;
    logic [7:0] wd_n;

    assign accept = (state == IDLE) && req_valid && req_ready;
    assign adv    = (state == IDLE) ? accept : done;
    assign tgt    = nxt_phase(state, SETUP_CYC == 0,
                              HOLD_CYC == 0, RECOVERY_CYC == 0);

    // On the accept edge the pins are loaded straight from the request.
    assign wr_n   = (state == IDLE) ? req_write : wr_q;
    assign addr_n = (state == IDLE) ? req_addr  : addr_q;
    assign wd_n   = (state == IDLE) ? req_wdata : wd_q;

    ppi_phase_timer #(
        .SETUP_CYC   (SETUP_CYC),
        .STROBE_CYC  (STROBE_CYC),
        .HOLD_CYC    (HOLD_CYC),
        .RECOVERY_CYC(RECOVERY_CYC)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (adv),
        .tgt  (tgt),
        .done (done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            nCS       <= 1'b1;
            nRD       <= 1'b1;
            nWR       <= 1'b1;
            A         <= 2'd0;
            Dout      <= 8'h00;
            Doe       <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 2'd0;
            wd_q      <= 8'h00;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                wr_q   <= req_write;
                addr_q <= req_addr;
                wd_q   <= req_wdata;
            end
            if (adv) begin
                state     <= tgt;
                req_ready <= (tgt == IDLE);
                // Din captured on the edge that ends the last strobe cycle.
                if (state == STROBE && !wr_q) begin
                    rsp_valid <= 1'b1;
                    rsp_rdata <= Din;
                end
                case (tgt)
                    SETUP, STROBE, HOLD: begin
                        nCS  <= 1'b0;
                        A    <= addr_n;
                        Dout <= wr_n ? wd_n : 8'h00;
                        Doe  <= wr_n;
                        nRD  <= !(tgt == STROBE && !wr_n);
                        nWR  <= !(tgt == STROBE && wr_n);
                    end
                    default: begin
                        nCS <= 1'b1;
                        nRD <= 1'b1;
                        nWR <= 1'b1;
                        Doe <= 1'b0;
                    end
                endcase
            end
        end
    end

    cfg_range : assert property (@(posedge clk) CFG_OK)
        else $error("ppi_bus_master: timing parameter out of range");

endmodule

// File: tb/tb_ppi_bus_master.sv
// Directed bench for ppi_bus_master: default timing instance plus a
// zero-optional-phase instance, vector table and hand-written sequences.
module tb_ppi_bus_master;
    import ppi_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       sel = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_write = 1'b0;
    logic [1:0] req_addr = 2'd0;
    logic [7:0] req_wdata = 8'h00;
    logic [7:0] din_val = 8'h00;
    logic [7:0] din_bus;

    logic       rdy0, rv0, ncs0, nrd0, nwr0, doe0;
    logic [7:0] rd0, dout0;
    logic [1:0] a0;
    logic       rdy1, rv1, ncs1, nrd1, nwr1, doe1;
    logic [7:0] rd1, dout1;
    logic [1:0] a1;

    logic       m_rdy, m_rv, m_ncs, m_nrd, m_nwr, m_doe;
    logic [7:0] m_rd, m_dout;
    logic [1:0] m_a;

    assign m_rdy  = sel ? rdy1  : rdy0;
    assign m_rv   = sel ? rv1   : rv0;
    assign m_ncs  = sel ? ncs1  : ncs0;
    assign m_nrd  = sel ? nrd1  : nrd0;
    assign m_nwr  = sel ? nwr1  : nwr0;
    assign m_doe  = sel ? doe1  : doe0;
    assign m_rd   = sel ? rd1   : rd0;
    assign m_dout = sel ? dout1 : dout0;
    assign m_a    = sel ? a1    : a0;

    // PPI model: drives its data only while nRD is low
    assign din_bus = !m_nrd ? din_val : 8'h00;

    ppi_bus_master u0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && !sel), .req_ready(rdy0),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0),
        .nCS(ncs0), .nRD(nrd0), .nWR(nwr0), .A(a0),
        .Dout(dout0), .Doe(doe0), .Din(din_bus)
    );

    ppi_bus_master #(
        .SETUP_CYC(0), .STROBE_CYC(1),
        .HOLD_CYC(0), .RECOVERY_CYC(0)
    ) u1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid && sel), .req_ready(rdy1),
        .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rv1), .rsp_rdata(rd1),
        .nCS(ncs1), .nRD(nrd1), .nWR(nwr1), .A(a1),
        .Dout(dout1), .Doe(doe1), .Din(din_bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                     nm, act, act, exp, exp);
        end
    endtask

    typedef struct {
        bit         sel;
        bit         w;
        logic [1:0] a;
        logic [7:0] wd;
        logic [7:0] din;
        int         ncs;
        int         stb;
        int         first;
        int         rsp;
        logic [7:0] rd;
        int         lat;
    } vec_t;

    vec_t tv[6];

    task automatic run_vec(input vec_t v, input int idx);
        int lat, ncs_n, stb_n, oth_n, rsp_n, first, bad, rule;
        logic [7:0] rd;
        logic stb, oth;
        lat = -1; ncs_n = 0; stb_n = 0; oth_n = 0; rsp_n = 0;
        first = -1; bad = 0; rule = 0; rd = 8'h00;
        @(negedge clk);
        sel = v.sel;
        req_valid = 1'b1;
        req_write = v.w;
        req_addr = v.a;
        req_wdata = v.wd;
        din_val = v.din;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = !v.w;
        req_addr = ~v.a;
        req_wdata = ~v.wd;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clk);
            stb = v.w ? m_nwr : m_nrd;
            oth = v.w ? m_nrd : m_nwr;
            if (!m_ncs) ncs_n++;
            if (!stb) begin
                stb_n++;
                if (first < 0) first = i;
            end
            if (!oth) oth_n++;
            if (m_rv) begin
                rsp_n++;
                rd = m_rd;
            end
            if (!m_ncs && (m_a != v.a || m_doe != v.w ||
                (v.w && m_dout != v.wd))) bad++;
            if ((!m_nrd && !m_nwr) ||
                (m_ncs && (!m_nrd || !m_nwr))) rule++;
            if (m_rdy) begin
                lat = i;
                break;
            end
        end
        chk($sformatf("v%0d_latency", idx), lat, v.lat);
        chk($sformatf("v%0d_ncs_low", idx), ncs_n, v.ncs);
        chk($sformatf("v%0d_strobe_low", idx), stb_n, v.stb);
        chk($sformatf("v%0d_strobe_start", idx), first, v.first);
        chk($sformatf("v%0d_wrong_strobe", idx), oth_n, 0);
        chk($sformatf("v%0d_rsp_pulses", idx), rsp_n, v.rsp);
        chk($sformatf("v%0d_pin_hold", idx), bad, 0);
        chk($sformatf("v%0d_strobe_rules", idx), rule, 0);
        if (!v.w) chk($sformatf("v%0d_rdata", idx), rd, v.rd);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt, rise, fall2, rule, rsp_n, k;
        logic prev;
        logic [7:0] rd;

        tv[0] = '{1'b0, 1'b1, CTRL,   8'h80, 8'h00, 5, 3, 1, 0, 8'h00, 7};
        tv[1] = '{1'b0, 1'b0, PORT_B, 8'h00, 8'hA5, 5, 3, 1, 1, 8'hA5, 7};
        tv[2] = '{1'b0, 1'b1, PORT_A, 8'h5A, 8'h00, 5, 3, 1, 0, 8'h00, 7};
        tv[3] = '{1'b0, 1'b0, PORT_C, 8'h00, 8'h3C, 5, 3, 1, 1, 8'h3C, 7};
        tv[4] = '{1'b1, 1'b0, PORT_B, 8'h00, 8'hC3, 1, 1, 0, 1, 8'hC3, 1};
        tv[5] = '{1'b1, 1'b1, PORT_C, 8'h0F, 8'h00, 1, 1, 0, 0, 8'h00, 1};

        repeat (2) @(negedge clk);
        chk("rst_ncs", ncs0, 1);
        chk("rst_nrd", nrd0, 1);
        chk("rst_nwr", nwr0, 1);
        chk("rst_a", a0, 0);
        chk("rst_dout", dout0, 0);
        chk("rst_doe", doe0, 0);
        chk("rst_rsp_valid", rv0, 0);
        chk("rst_rsp_rdata", rd0, 0);
        chk("rst_ready", rdy0, 1);
        chk("rst_ready_zero_cfg", rdy1, 1);
        chk("rst_ncs_zero_cfg", ncs1, 1);
        reset = 1'b0;

        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rv0 || rv1 || !ncs0 || !ncs1 || !rdy0) cnt++;
        end
        chk("idle_quiet", cnt, 0);

        for (int i = 0; i < 6; i++) run_vec(tv[i], i);

        // back-to-back: write then read with req_valid held high
        @(negedge clk);
        sel = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr = PORT_A;
        req_wdata = 8'h11;
        din_val = 8'h77;
        @(negedge clk);
        req_write = 1'b0;
        req_addr = PORT_C;
        rise = -1; fall2 = -1; rule = 0; rsp_n = 0; rd = 8'h00;
        prev = 1'b0;
        for (int t = 0; t < 30; t++) begin
            if (t > 0) @(negedge clk);
            if (!prev && m_ncs && rise < 0) rise = t;
            if (prev && !m_ncs && rise >= 0 && fall2 < 0) begin
                fall2 = t;
                req_valid = 1'b0;
            end
            prev = m_ncs;
            if ((!m_nrd && !m_nwr) ||
                (m_ncs && (!m_nrd || !m_nwr))) rule++;
            if (m_rv) begin
                rsp_n++;
                rd = m_rd;
            end
        end
        req_valid = 1'b0;
        chk("b2b_ncs_gap", fall2 - rise, 3);
        chk("b2b_strobe_rules", rule, 0);
        chk("b2b_rsp_pulses", rsp_n, 1);
        chk("b2b_rdata", rd, 8'h77);
        chk("b2b_ready_end", m_rdy, 1);

        // reset during the strobe of a read
        @(negedge clk);
        sel = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr = PORT_B;
        din_val = 8'h5A;
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (nrd0 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("rstmid_strobe_seen", nrd0, 0);
        #1 reset = 1'b1;
        #1;
        chk("rstmid_ncs", ncs0, 1);
        chk("rstmid_nrd", nrd0, 1);
        chk("rstmid_nwr", nwr0, 1);
        chk("rstmid_ready", rdy0, 1);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rv0) cnt++;
        end
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rv0 || !ncs0) cnt++;
        end
        chk("rstmid_dropped", cnt, 0);
        run_vec(tv[0], 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
